// File: rtl/boot_loader.sv
// Framed-stream program loader for the 8-bit multicycle core.
// Holds the core in reset, fills memory, checks the sum, then hands over.
module boot_loader #(
  parameter logic [7:0] BASE_ADR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic [7:0] cpu_adr,
  input  logic [7:0] cpu_writedata,
  input  logic       cpu_memwrite,
  input  logic       cpu_memread,
  output logic [7:0] mem_adr,
  output logic [7:0] mem_writedata,
  output logic       mem_write,
  output logic       mem_read,
  output logic       cpu_reset,
  output logic       done,
  output logic       error,
  output logic [7:0] byte_count
);

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CHK,
    RUN,
    ERR
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] rem_q, rem_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] wdat_q, wdat_d;
  logic       wr_q, wr_d;
  logic       xfer;

  assign xfer = s_valid & s_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      sum_q  <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      adr_q  <= '0;
      wdat_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      sum_q  <= sum_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      adr_q  <= adr_d;
      wdat_q <= wdat_d;
      wr_q   <= wr_d;
    end
  end

  // The write strobe is a one-cycle pulse per accepted payload byte.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    wr_d    = 1'b0;
    unique case (state_q)
      HDR: begin
        if (xfer) begin
          rem_d   = (s_data == 8'd0) ? 9'd256
                                     : {1'b0, s_data};
          sum_d   = 8'd0;
          ptr_d   = BASE_ADR;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          wr_d   = 1'b1;
          adr_d  = ptr_q;
          wdat_d = s_data;
          sum_d  = sum_q + s_data;
          ptr_d  = ptr_q + 8'd1;
          cnt_d  = cnt_q + 8'd1;
          rem_d  = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (xfer) begin
          state_d = (s_data == sum_q) ? RUN : ERR;
        end
      end
      RUN: state_d = RUN;
      ERR: state_d = ERR;
      default: state_d = HDR;
    endcase
  end

  always_comb begin
    s_ready       = 1'b0;
    cpu_reset     = 1'b1;
    done          = 1'b0;
    error         = 1'b0;
    mem_adr       = adr_q;
    mem_writedata = wdat_q;
    mem_write     = wr_q;
    mem_read      = 1'b0;
    unique case (state_q)
      HDR, DATA, CHK: begin
        s_ready = 1'b1;
      end
      RUN: begin
        cpu_reset     = 1'b0;
        done          = 1'b1;
        mem_adr       = cpu_adr;
        mem_writedata = cpu_writedata;
        mem_write     = cpu_memwrite;
        mem_read      = cpu_memread;
      end
      ERR: begin
        error     = 1'b1;
        mem_write = 1'b0;
      end
      default: begin
        mem_write = 1'b0;
      end
    endcase
  end

  assign byte_count = cnt_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: random frames, throttling, resets.
// Expected memory writes are queued by stimulus and popped by a monitor.
module tb_boot_loader;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic [7:0] cpu_adr = 8'h00;
  logic [7:0] cpu_writedata = 8'h00;
  logic       cpu_memwrite = 1'b0;
  logic       cpu_memread = 1'b0;
  logic [7:0] mem_adr;
  logic [7:0] mem_writedata;
  logic       mem_write;
  logic       mem_read;
  logic       cpu_reset;
  logic       done;
  logic       error;
  logic [7:0] byte_count;

  int checks = 0;
  int failures = 0;
  logic [15:0] expq[$];
  logic [7:0]  pl[$];

  always #5 clk = ~clk;

  boot_loader #(.BASE_ADR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .cpu_adr(cpu_adr),
    .cpu_writedata(cpu_writedata),
    .cpu_memwrite(cpu_memwrite),
    .cpu_memread(cpu_memread),
    .mem_adr(mem_adr),
    .mem_writedata(mem_writedata),
    .mem_write(mem_write),
    .mem_read(mem_read),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .byte_count(byte_count)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Loader-mode monitor: every write pulse must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1 && cpu_reset === 1'b1) begin
      chk("loader_memread", {31'd0, mem_read}, 32'd0);
      if (mem_write === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL extra_write actual=%0h:%0h required=none",
                   mem_adr, mem_writedata);
        end else begin
          logic [15:0] e;
          e = expq.pop_front();
          if ({mem_adr, mem_writedata} !== e) begin
            failures++;
            $display("FAIL write actual=%0h:%0h required=%0h:%0h",
                     mem_adr, mem_writedata, e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_mem_adr"}, {24'd0, mem_adr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_writedata}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_byte_count"}, {24'd0, byte_count}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    s_valid = 1'b0;
    #1;
    chk_reset_vals(tag);
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit wr,
                      input logic [7:0] adr, input bit thr);
    if (thr) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        s_valid = 1'b0;
        s_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data = b;
    cpu_adr = 8'($urandom);
    cpu_writedata = 8'($urandom);
    cpu_memwrite = 1'($urandom);
    cpu_memread = 1'($urandom);
    if (wr) expq.push_back({adr, b});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Sends length, payload from pl, checksum; stops early at stop_at.
  task automatic frame(input int n, input bit good,
                       input bit thr, input int stop_at);
    int sum;
    logic [7:0] lenb;
    logic [7:0] c;
    sum = 0;
    lenb = n[7:0];
    send(lenb, 1'b0, 8'h00, thr);
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) return;
      sum = (sum + int'(pl[i])) % 256;
      send(pl[i], 1'b1, 8'((int'(BASE) + i) % 256), thr);
    end
    c = good ? 8'(sum) : 8'((sum + 1) % 256);
    send(c, 1'b0, 8'h00, thr);
    cpu_memwrite = 1'b0;
    cpu_memread = 1'b0;
    #1;
    chk("end_mem_write", {31'd0, mem_write}, 32'd0);
    chk("end_queue_empty", expq.size(), 32'd0);
    chk("end_byte_count", {24'd0, byte_count}, n % 256);
    chk("end_done", {31'd0, done}, {31'd0, good});
    chk("end_error", {31'd0, error}, {31'd0, !good});
    chk("end_cpu_reset", {31'd0, cpu_reset}, {31'd0, !good});
    chk("end_s_ready", {31'd0, s_ready}, 32'd0);
  endtask

  initial begin
    do_reset("rst0");

    pl = '{8'hAA, 8'hBB, 8'hCC};
    frame(3, 1'b1, 1'b0, -1);
    cpu_adr = 8'h5A;
    cpu_writedata = 8'hC3;
    cpu_memwrite = 1'b1;
    cpu_memread = 1'b0;
    #1;
    chk("run_mem_adr", {24'd0, mem_adr}, 32'h5A);
    chk("run_mem_wdata", {24'd0, mem_writedata}, 32'hC3);
    chk("run_mem_write", {31'd0, mem_write}, 32'd1);
    chk("run_mem_read0", {31'd0, mem_read}, 32'd0);
    cpu_memwrite = 1'b0;
    cpu_memread = 1'b1;
    #1;
    chk("run_mem_read1", {31'd0, mem_read}, 32'd1);
    chk("run_mem_write0", {31'd0, mem_write}, 32'd0);
    cpu_memread = 1'b0;

    do_reset("rst1");
    pl = '{8'h01, 8'h02};
    frame(2, 1'b0, 1'b0, -1);
    s_valid = 1'b1;
    s_data = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("err_byte_count", {24'd0, byte_count}, 32'd2);
    chk("err_error", {31'd0, error}, 32'd1);
    chk("err_s_ready", {31'd0, s_ready}, 32'd0);
    chk("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    do_reset("rst2");
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    frame(256, 1'b1, 1'b0, -1);

    do_reset("rst3");
    pl = '{8'hAA, 8'hBB, 8'hCC};
    frame(3, 1'b1, 1'b1, -1);

    do_reset("rst4");
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame(4, 1'b1, 1'b0, 2);
    @(negedge clk);
    #2;
    do_reset("midrst");
    frame(4, 1'b1, 1'b0, -1);

    for (int k = 0; k < 6; k++) begin
      int n;
      bit g;
      n = $urandom_range(1, 40);
      g = 1'($urandom_range(0, 1));
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      do_reset("rstr");
      frame(n, g, 1'b1, -1);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
